// File: rtl/conv_fifo_sync.sv
// Parametrised single-clock FIFO with fill level, almost flags and sticky errors.
// Define CONV_FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle registered read.
module conv_fifo_sync #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_THRESH = 7,
    parameter int unsigned AE_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] level,
    input  logic                       clr_err,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;

    assign full         = (level == LW'(DEPTH));
    assign empty        = (level == '0);
    assign almost_full  = (level >= LW'(AF_THRESH));
    assign almost_empty = (level <= LW'(AE_THRESH));

    // Gating on full/empty alone yields the read-wins-when-full and write-wins-when-empty rules.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            if (wr_acc && !rd_acc) begin
                level <= level + LW'(1);
            end else if (rd_acc && !wr_acc) begin
                level <= level - LW'(1);
            end
            // A fresh error event overrides a simultaneous clear.
            overflow  <= (overflow  && !clr_err) || (wr_en && full);
            underflow <= (underflow && !clr_err) || (rd_en && empty);
        end
    end

`ifdef CONV_FIFO_FWFT_EN
    assign rd_data  = mem[rd_ptr];
    assign rd_valid = !empty;
`else
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_fifo_sync.sv
// Directed self-checking bench for conv_fifo_sync: DEPTH=8 instance plus DEPTH=5 wrap instance.
module tb_conv_fifo_sync;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en, rd_en, clr_err;
    logic [7:0] wr_data, rd_data;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] level;

    logic       b_wr_en, b_rd_en, b_clr_err;
    logic [7:0] b_wr_data, b_rd_data;
    logic       b_rd_valid, b_full, b_empty, b_almost_full, b_almost_empty, b_overflow, b_underflow;
    logic [2:0] b_level;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    conv_fifo_sync #(.WIDTH(8), .DEPTH(8), .AF_THRESH(7), .AE_THRESH(1)) dut_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
        .clr_err(clr_err), .overflow(overflow), .underflow(underflow)
    );

    conv_fifo_sync #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) dut_b (
        .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_data(b_wr_data), .rd_en(b_rd_en),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .full(b_full), .empty(b_empty),
        .almost_full(b_almost_full), .almost_empty(b_almost_empty), .level(b_level),
        .clr_err(b_clr_err), .overflow(b_overflow), .underflow(b_underflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tests++;
        if ({level, empty, full, almost_empty, almost_full, rd_valid, overflow, underflow} !==
            {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: level=%0d empty=%b full=%b ae=%b af=%b rv=%b ov=%b un=%b, required 0 1 0 1 0 0 0 0",
                     level, empty, full, almost_empty, almost_full, rd_valid, overflow, underflow);
        end
`ifndef CONV_FIFO_FWFT_EN
        tests++;
        if (rd_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_rd_data: got %h required 00", rd_data);
        end
`endif
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1;
            wr_data = base + 8'(i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            tick();
            tests++;
            if ({level, full, almost_full, empty, almost_empty} !==
                {4'(i), (i == 8), (i >= 7), 1'b0, (i <= 1)}) begin
                fails++;
                $display("FAIL fill_%0d: level=%0d full=%b af=%b empty=%b ae=%b, required %0d %b %b 0 %b",
                         i, level, full, almost_full, empty, almost_empty, i, (i == 8), (i >= 7), (i <= 1));
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            rd_en = 1'b1;
`ifdef CONV_FIFO_FWFT_EN
            tests++;
            if ({rd_valid, rd_data} !== {1'b1, 8'(i)}) begin
                fails++;
                $display("FAIL drain_head_%0d: rv=%b data=%h, required 1 %h", i, rd_valid, rd_data, 8'(i));
            end
`endif
            tick();
`ifndef CONV_FIFO_FWFT_EN
            tests++;
            if ({rd_valid, rd_data} !== {1'b1, 8'(i)}) begin
                fails++;
                $display("FAIL drain_data_%0d: rv=%b data=%h, required 1 %h", i, rd_valid, rd_data, 8'(i));
            end
`endif
            tests++;
            if ({level, empty, almost_empty} !== {4'(8 - i), (i == 8), (i >= 7)}) begin
                fails++;
                $display("FAIL drain_level_%0d: level=%0d empty=%b ae=%b, required %0d %b %b",
                         i, level, empty, almost_empty, 8 - i, (i == 8), (i >= 7));
            end
        end
        // Read on empty: rejected, underflow latched.
        tick();
        tests++;
        if ({rd_valid, underflow, level} !== {1'b0, 1'b1, 4'd0}) begin
            fails++;
            $display("FAIL read_empty: rv=%b un=%b level=%0d, required 0 1 0", rd_valid, underflow, level);
        end
`ifndef CONV_FIFO_FWFT_EN
        tests++;
        if (rd_data !== 8'h08) begin
            fails++;
            $display("FAIL read_empty_hold: got %h required 08", rd_data);
        end
`endif
        rd_en = 1'b0;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tests++;
        if ({overflow, underflow} !== 2'b00) begin
            fails++;
            $display("FAIL clr_underflow: ov=%b un=%b, required 0 0", overflow, underflow);
        end
    endtask

    task automatic test_simultaneous();
        fill(8'h10);
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hAA;
        tick();
        wr_en = 1'b0;
        tests++;
        if ({level, overflow, rd_valid} !== {4'd7, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL full_both: level=%0d ov=%b rv=%b, required 7 1 1", level, overflow, rd_valid);
        end
`ifndef CONV_FIFO_FWFT_EN
        tests++;
        if (rd_data !== 8'h11) begin
            fails++;
            $display("FAIL full_both_data: got %h required 11", rd_data);
        end
`endif
        for (int i = 2; i <= 8; i++) begin
`ifdef CONV_FIFO_FWFT_EN
            tests++;
            if (rd_data !== 8'(8'h10 + i)) begin
                fails++;
                $display("FAIL full_both_rest_%0d: got %h required %h", i, rd_data, 8'(8'h10 + i));
            end
`endif
            tick();
`ifndef CONV_FIFO_FWFT_EN
            tests++;
            if (rd_data !== 8'(8'h10 + i)) begin
                fails++;
                $display("FAIL full_both_rest_%0d: got %h required %h", i, rd_data, 8'(8'h10 + i));
            end
`endif
        end
        rd_en = 1'b0;
        tests++;
        if ({empty, level} !== {1'b1, 4'd0}) begin
            fails++;
            $display("FAIL no_aa_stored: empty=%b level=%0d, required 1 0", empty, level);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h55;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        tests++;
        if ({level, underflow, overflow} !== {4'd1, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL empty_both: level=%0d un=%b ov=%b, required 1 1 0", level, underflow, overflow);
        end
`ifdef CONV_FIFO_FWFT_EN
        tests++;
        if ({rd_valid, rd_data} !== {1'b1, 8'h55}) begin
            fails++;
            $display("FAIL empty_both_head: rv=%b data=%h, required 1 55", rd_valid, rd_data);
        end
`else
        tests++;
        if (rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL empty_both_nobypass: rv=%b required 0", rd_valid);
        end
`endif
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
`ifndef CONV_FIFO_FWFT_EN
        tests++;
        if ({rd_valid, rd_data} !== {1'b1, 8'h55}) begin
            fails++;
            $display("FAIL empty_both_read: rv=%b data=%h, required 1 55", rd_valid, rd_data);
        end
`endif
        tests++;
        if (level !== 4'd0) begin
            fails++;
            $display("FAIL empty_both_level: got %0d required 0", level);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_err_clear();
        fill(8'h20);
        wr_en = 1'b1;
        tick();
        tests++;
        if ({overflow, level} !== {1'b1, 4'd8}) begin
            fails++;
            $display("FAIL ov_set: ov=%b level=%0d, required 1 8", overflow, level);
        end
        wr_en = 1'b0; clr_err = 1'b1;
        tick();
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL ov_clear: got %b required 0", overflow);
        end
        wr_en = 1'b1;
        tick();
        tests++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL ov_set_wins: got %b required 1", overflow);
        end
        wr_en = 1'b0; clr_err = 1'b0;
        tick();
        tests++;
        if ({overflow, underflow} !== 2'b10) begin
            fails++;
            $display("FAIL ov_sticky: ov=%b un=%b, required 1 0", overflow, underflow);
        end
    endtask

    task automatic test_reset_mid();
        rd_en = 1'b1;
        repeat (5) tick();
        tests++;
        if (level !== 4'd3) begin
            fails++;
            $display("FAIL pre_reset_level: got %0d required 3", level);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1; rd_en = 1'b0;
        tests++;
        if ({level, empty, rd_valid, overflow, underflow} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_mid: level=%0d empty=%b rv=%b ov=%b un=%b, required 0 1 0 0 0",
                     level, empty, rd_valid, overflow, underflow);
        end
`ifndef CONV_FIFO_FWFT_EN
        tests++;
        if (rd_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_mid_data: got %h required 00", rd_data);
        end
`endif
    endtask

`ifdef CONV_FIFO_FWFT_EN
    task automatic test_fwft();
        wr_en = 1'b1; wr_data = 8'h3C;
        tick();
        wr_data = 8'h3D;
        tick();
        wr_en = 1'b0;
        tests++;
        if ({rd_valid, rd_data, level} !== {1'b1, 8'h3C, 4'd2}) begin
            fails++;
            $display("FAIL fwft_head: rv=%b data=%h level=%0d, required 1 3c 2", rd_valid, rd_data, level);
        end
        rd_en = 1'b1;
        tick();
        tests++;
        if ({rd_valid, rd_data} !== {1'b1, 8'h3D}) begin
            fails++;
            $display("FAIL fwft_pop: rv=%b data=%h, required 1 3d", rd_valid, rd_data);
        end
        tick();
        rd_en = 1'b0;
        tests++;
        if ({rd_valid, empty} !== 2'b01) begin
            fails++;
            $display("FAIL fwft_empty: rv=%b empty=%b, required 0 1", rd_valid, empty);
        end
    endtask
`endif

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) begin
            b_wr_en = 1'b1; b_wr_data = 8'(8'h40 + i);
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            b_wr_en = 1'b1; b_rd_en = 1'b1; b_wr_data = 8'(8'h43 + i);
`ifdef CONV_FIFO_FWFT_EN
            tests++;
            if ({b_rd_valid, b_rd_data} !== {1'b1, 8'(8'h40 + i)}) begin
                fails++;
                $display("FAIL wrap_%0d: rv=%b data=%h, required 1 %h", i, b_rd_valid, b_rd_data, 8'(8'h40 + i));
            end
`endif
            tick();
`ifndef CONV_FIFO_FWFT_EN
            tests++;
            if ({b_rd_valid, b_rd_data} !== {1'b1, 8'(8'h40 + i)}) begin
                fails++;
                $display("FAIL wrap_%0d: rv=%b data=%h, required 1 %h", i, b_rd_valid, b_rd_data, 8'(8'h40 + i));
            end
`endif
            tests++;
            if ({b_level, b_full, b_empty} !== {3'd3, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL wrap_level_%0d: level=%0d full=%b empty=%b, required 3 0 0", i, b_level, b_full, b_empty);
            end
        end
        b_wr_en = 1'b0; b_rd_en = 1'b0;
        tests++;
        if ({b_almost_full, b_almost_empty, b_overflow, b_underflow} !== 4'b0000) begin
            fails++;
            $display("FAIL wrap_flags: af=%b ae=%b ov=%b un=%b, required 0 0 0 0",
                     b_almost_full, b_almost_empty, b_overflow, b_underflow);
        end
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
        b_wr_en = 1'b0; b_rd_en = 1'b0; b_clr_err = 1'b0; b_wr_data = '0;
        tick();
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_err_clear();
        test_reset_mid();
`ifdef CONV_FIFO_FWFT_EN
        test_fwft();
`endif
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv_fifo_sync.md
Name: conv_fifo_sync

Overview:
- Parametrised synchronous single-clock FIFO; next generation of the encoder's 8x8 byte buffer.
- Sits between the convolutional encoder output and the downstream framer.
- Adds over the 8x8 byte buffer:
  - configurable width and depth, including non-power-of-2 depth;
  - fill level output;
  - programmable almost-full / almost-empty thresholds;
  - sticky overflow/underflow error flags with clear.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 8, number of storage entries (>=2; power of 2 not required).
- AF_THRESH, 7, almost_full asserts when level >= AF_THRESH (1..DEPTH).
- AE_THRESH, 1, almost_empty asserts when level <= AE_THRESH (0..DEPTH-1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous reset, active-low.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read request.
- rd_data  out  WIDTH  read data, registered.
- rd_valid  out  1  rd_data holds a newly popped word.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= AF_THRESH.
- almost_empty  out  1  level <= AE_THRESH.
- level  out  $clog2(DEPTH+1)  current number of stored words.
- clr_err  in  1  clears overflow/underflow (synchronous).
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (reset==0 at clk edge):
  - wr_ptr, rd_ptr, level, rd_data, rd_valid, overflow and underflow all go to 0.
  - Storage array is not cleared.
  - Reset dominates every other input, including mid-burst.
  - After reset: empty=1, full=0, almost_empty=1 (AE_THRESH>=0), almost_full=0.
- Write accept: wr_en && !full.
  - mem[wr_ptr] <= wr_data.
  - wr_ptr increments, wrapping from DEPTH-1 to 0 (explicit compare, not modulo-by-overflow).
- Read accept: rd_en && !empty.
  - rd_data <= mem[rd_ptr]; rd_ptr increments with the same wrap rule.
  - rd_valid=1 on the following cycle for exactly one cycle per accepted read.
  - Latency: 1 clock from the rd_en edge to rd_data/rd_valid.
- Rejected read: rd_valid=0 next cycle; rd_data holds its previous value.
- Level update:
  - write only: +1;
  - read only: -1;
  - both accepted: unchanged;
  - neither: unchanged.
- Simultaneous rd_en && wr_en:
  - When full: read accepted, write rejected, overflow set. Level goes to DEPTH-1.
  - When empty: write accepted, read rejected, underflow set. Level goes to 1. No bypass: the new word is readable at the earliest on the next rd_en.
  - Otherwise both accepted.
- Flags:
  - full, empty, almost_full and almost_empty are combinational decodes of registered level.
  - They are valid in the same cycle level changes.
- Error flags:
  - overflow set on (wr_en && full); underflow set on (rd_en && empty).
  - Both hold until clr_err=1 or reset.
  - If clr_err and a new error event occur in the same cycle, set wins (flag stays 1).
- Invariants: level never exceeds DEPTH and never underflows below 0. Rejected operations never move pointers or corrupt storage.

Optional Feature:
- Macro: CONV_FIFO_FWFT_EN.
- Defined (first-word-fall-through mode):
  - rd_data always shows mem[rd_ptr] and rd_valid = !empty.
  - rd_en acts as acknowledge: it pops the current head.
  - After reset: rd_valid=0; rd_data is don't-care while empty.
  - A write into an empty FIFO makes rd_valid=1 on the next cycle.
  - Level, flags and error rules are unchanged.
- Undefined: standard mode described under Behaviour (1-cycle registered read latency).

Test Plan:
- Reset, then write 0x01..0x08 (DEPTH=8) -> level 1..8; full=1 after 8th write; almost_full=1 from level 7; empty=0.
- From full, read 8 times -> rd_data 0x01..0x08, each one cycle after rd_en with rd_valid=1; then empty=1, level=0, almost_empty=1 at level<=1.
- Full FIFO, wr_en=rd_en=1 with wr_data=0xAA -> level=7, overflow=1, 0xAA not stored; empty FIFO, wr_en=rd_en=1 with 0x55 -> level=1, underflow=1, next read returns 0x55.
- DEPTH=5, 12 interleaved write/read pairs -> data order preserved across pointer wrap 4->0; level never exceeds 5.
- Set overflow, then clr_err=1 with wr_en=0 -> overflow=0 next cycle; clr_err=1 with wr_en=1 while full -> overflow stays 1.
- Assert reset with level=3 during an active read -> next cycle level=0, empty=1, rd_valid=0, rd_data=0, errors cleared. With CONV_FIFO_FWFT_EN: a write of 0x3C to an empty FIFO gives rd_valid=1, rd_data=0x3C next cycle.
